// File: rtl/alu64_dispatch.sv
// alu64_dispatch -- issue/writeback controller sitting in front of ALU64.
//
// Owns a 16 x 64-bit register file with a 2-bit size tag per entry and a
// busy scoreboard. Instructions arrive on a valid/ready port and are issued
// to ALU64 once none of their sources or their destination is busy. Results
// come back a fixed RES_LAT cycles after ACT. ALU64's RDY/DSTo are not
// aligned with R, so the destination tag travels down a local shift register.
//
// Optional build macro: ALU64_DISPATCH_FWD_EN
//   When defined, a register being written back this cycle counts as not
//   busy, and its operand and size are bypassed from R and the captured SR.
//
// Ports
//   CLK, RESET            clock (rising edge), async active-low reset
//   IVALID/IREADY         instruction handshake
//   IOP, IDST, ISRCA..D   opcode, destination, four source registers
//   ICIN                  carry-in
//   WEN/WADDR/WDATA/WSIZE external register load (dropped if target busy)
//   RADDR -> RDATA/RSIZE  combinational debug read
//   ACT, CIN, OpCODE, DSTi, A..D, SA..SD   registered issue to ALU64
//   R, SR, OVR, Zero, Sign, COUT           results from ALU64
//   FLAGS                 {carry, OVR, Zero, Sign} of the last writeback
//   BUSY                  any scoreboard bit or pipeline slot valid
module alu64_dispatch #(
    parameter int RES_LAT = 2,
    parameter int SR_LAT  = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IVALID,
    output logic        IREADY,
    input  logic [2:0]  IOP,
    input  logic [3:0]  IDST,
    input  logic [3:0]  ISRCA,
    input  logic [3:0]  ISRCB,
    input  logic [3:0]  ISRCC,
    input  logic [3:0]  ISRCD,
    input  logic        ICIN,
    input  logic        WEN,
    input  logic [3:0]  WADDR,
    input  logic [63:0] WDATA,
    input  logic [1:0]  WSIZE,
    input  logic [3:0]  RADDR,
    output logic [63:0] RDATA,
    output logic [1:0]  RSIZE,
    output logic        ACT,
    output logic        CIN,
    output logic [2:0]  OpCODE,
    output logic [3:0]  DSTi,
    output logic [63:0] A,
    output logic [63:0] B,
    output logic [63:0] C,
    output logic [63:0] D,
    output logic [1:0]  SA,
    output logic [1:0]  SB,
    output logic [1:0]  SC,
    output logic [1:0]  SD,
    input  logic [63:0] R,
    input  logic [1:0]  SR,
    input  logic        OVR,
    input  logic        Zero,
    input  logic        Sign,
    input  logic [15:0] COUT,
    output logic [3:0]  FLAGS,
    output logic        BUSY
);

    logic [15:0][63:0] regs;
    logic [15:0][1:0]  size;
    logic [15:0]       busy;

    // Tag pipeline: slot k holds the op whose ACT was k+1 cycles ago.
    logic [RES_LAT-1:0]      vld_pipe;
    logic [RES_LAT-1:0][3:0] dst_pipe;
    logic [RES_LAT-1:0][1:0] sr_pipe;

    logic        wb_vld;
    logic [3:0]  wb_dst;
    logic [1:0]  wb_sr;
    logic [15:0] wb_clr;
    logic [15:0] busy_eff;
    logic        accept;

    logic [3:0][3:0]  src;
    logic [3:0][63:0] opnd;
    logic [3:0][1:0]  opsz;

    // Only COUT[15] (final carry) is meaningful here.
    logic unused_cout_lo;
    assign unused_cout_lo = ^COUT[14:0];

    assign wb_vld = vld_pipe[RES_LAT-1];
    assign wb_dst = dst_pipe[RES_LAT-1];
    // If SR arrives in the writeback cycle itself it is used directly.
    assign wb_sr  = (SR_LAT >= RES_LAT) ? SR : sr_pipe[RES_LAT-1];
    assign wb_clr = wb_vld ? (16'd1 << wb_dst) : 16'd0;

`ifdef ALU64_DISPATCH_FWD_EN
    assign busy_eff = busy & ~wb_clr;
`else
    // The registered busy bit only drops at the writeback edge, so a
    // dependent op sees it for the whole writeback cycle.
    assign busy_eff = busy;
`endif

    assign IREADY = RESET & ~WEN
                  & ~busy_eff[ISRCA] & ~busy_eff[ISRCB]
                  & ~busy_eff[ISRCC] & ~busy_eff[ISRCD]
                  & ~busy_eff[IDST];
    assign accept = IVALID & IREADY;

    assign src = {ISRCD, ISRCC, ISRCB, ISRCA};

    always_comb begin
        opnd = '0;
        opsz = '0;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU64_DISPATCH_FWD_EN
            if (wb_vld && (src[i] == wb_dst)) begin
                opnd[i] = R;
                opsz[i] = wb_sr;
            end else begin
                opnd[i] = regs[src[i]];
                opsz[i] = size[src[i]];
            end
`else
            opnd[i] = regs[src[i]];
            opsz[i] = size[src[i]];
`endif
        end
    end

    assign RDATA = regs[RADDR];
    assign RSIZE = size[RADDR];
    assign BUSY  = (|busy) | (|vld_pipe);

    // Issue registers toward ALU64.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ACT    <= 1'b0;
            CIN    <= 1'b0;
            OpCODE <= '0;
            DSTi   <= '0;
            A      <= '0;
            B      <= '0;
            C      <= '0;
            D      <= '0;
            SA     <= '0;
            SB     <= '0;
            SC     <= '0;
            SD     <= '0;
        end else begin
            ACT <= accept;
            if (accept) begin
                CIN    <= ICIN;
                OpCODE <= IOP;
                DSTi   <= IDST;
                A      <= opnd[0];
                B      <= opnd[1];
                C      <= opnd[2];
                D      <= opnd[3];
                SA     <= opsz[0];
                SB     <= opsz[1];
                SC     <= opsz[2];
                SD     <= opsz[3];
            end
        end
    end

    // Tag/SR shift register; SR is sampled into the slot that is being
    // loaded in the cycle SR becomes valid.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vld_pipe <= '0;
            dst_pipe <= '0;
            sr_pipe  <= '0;
        end else begin
            vld_pipe[0] <= ACT;
            dst_pipe[0] <= DSTi;
            sr_pipe[0]  <= (SR_LAT == 0) ? SR : 2'b00;
            for (int k = 1; k < RES_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                dst_pipe[k] <= dst_pipe[k-1];
                sr_pipe[k]  <= (k == SR_LAT) ? SR : sr_pipe[k-1];
            end
        end
    end

    // Register file, size tags, scoreboard and flags.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            regs  <= '0;
            size  <= '0;
            busy  <= '0;
            FLAGS <= '0;
        end else begin
            if (wb_vld) begin
                regs[wb_dst] <= R;
                size[wb_dst] <= wb_sr;
                FLAGS        <= {COUT[15], OVR, Zero, Sign};
            end
            // A busy target means a result is in flight; that result wins.
            if (WEN && !busy[WADDR]) begin
                regs[WADDR] <= WDATA;
                size[WADDR] <= WSIZE;
            end
            // Clear before set so an issue to the register retiring this
            // cycle (possible only with bypass) keeps it busy.
            busy <= (busy & ~wb_clr) | (accept ? (16'd1 << IDST) : 16'd0);
        end
    end

endmodule

// File: tb/tb_alu64_dispatch.sv
// Directed bench for alu64_dispatch. A small ALU64 stand-in performs a
// size-aware add (result at ACT+2, SR at ACT+1) so writebacks can be checked
// against hand-computed values.
module tb_alu64_dispatch;

`ifdef ALU64_DISPATCH_FWD_EN
    localparam int EXP_STALLS = 2;
`else
    localparam int EXP_STALLS = 3;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        IVALID, IREADY;
    logic [2:0]  IOP;
    logic [3:0]  IDST, ISRCA, ISRCB, ISRCC, ISRCD;
    logic        ICIN, WEN;
    logic [3:0]  WADDR, RADDR;
    logic [63:0] WDATA, RDATA;
    logic [1:0]  WSIZE, RSIZE;
    logic        ACT, CIN;
    logic [2:0]  OpCODE;
    logic [3:0]  DSTi;
    logic [63:0] A, B, C, D, R;
    logic [1:0]  SA, SB, SC, SD, SR;
    logic        OVR, Zero, Sign;
    logic [15:0] COUT;
    logic [3:0]  FLAGS;
    logic        BUSY;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    alu64_dispatch dut (
        .CLK(CLK), .RESET(RESET), .IVALID(IVALID), .IREADY(IREADY),
        .IOP(IOP), .IDST(IDST), .ISRCA(ISRCA), .ISRCB(ISRCB),
        .ISRCC(ISRCC), .ISRCD(ISRCD), .ICIN(ICIN), .WEN(WEN),
        .WADDR(WADDR), .WDATA(WDATA), .WSIZE(WSIZE), .RADDR(RADDR),
        .RDATA(RDATA), .RSIZE(RSIZE), .ACT(ACT), .CIN(CIN),
        .OpCODE(OpCODE), .DSTi(DSTi), .A(A), .B(B), .C(C), .D(D),
        .SA(SA), .SB(SB), .SC(SC), .SD(SD), .R(R), .SR(SR),
        .OVR(OVR), .Zero(Zero), .Sign(Sign), .COUT(COUT),
        .FLAGS(FLAGS), .BUSY(BUSY)
    );

    // ALU64 stand-in: add A+B+CIN at the width selected by SA.
    logic [6:0]  m_top;
    logic [63:0] m_msk, m_res;
    logic [64:0] m_sum;
    logic        m_c, m_ovr, m_z, m_s;
    always_comb begin
        m_top = 7'd63;
        case (SA)
            2'd0: m_top = 7'd7;
            2'd1: m_top = 7'd15;
            2'd2: m_top = 7'd31;
            default: m_top = 7'd63;
        endcase
        m_msk = (m_top == 7'd63) ? '1 : ((64'd1 << (m_top + 7'd1)) - 64'd1);
        m_sum = {1'b0, A & m_msk} + {1'b0, B & m_msk} + {64'd0, CIN};
        m_res = m_sum[63:0] & m_msk;
        m_c   = m_sum[m_top + 7'd1];
        m_s   = m_res[m_top];
        m_z   = (m_res == 64'd0);
        m_ovr = (A[m_top] == B[m_top]) && (m_s != A[m_top]);
    end

    logic [63:0] s1_r = '0, s2_r = '0;
    logic [1:0]  s1_sr = '0;
    logic [3:0]  s1_f = '0, s2_f = '0;
    always_ff @(posedge CLK) begin
        if (ACT) begin
            s1_r  <= m_res;
            s1_sr <= SA;
            s1_f  <= {m_c, m_ovr, m_z, m_s};
        end
        s2_r <= s1_r;
        s2_f <= s1_f;
    end
    assign R    = s2_r;
    assign SR   = s1_sr;
    assign COUT = {s2_f[3], 15'd0};
    assign OVR  = s2_f[2];
    assign Zero = s2_f[1];
    assign Sign = s2_f[0];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_op(input logic [3:0] dst, input logic [3:0] sa, input logic [3:0] sb);
        IVALID = 1'b1; IOP = 3'b011; IDST = dst;
        ISRCA = sa; ISRCB = sb; ISRCC = 4'd0; ISRCD = 4'd0; ICIN = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (BUSY && n < 30) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, BUSY}, 64'd0);
    endtask

    initial begin
        int stalls;
        logic acc;
        IVALID = 1'b1; IOP = 3'b011; IDST = 4'd3; ISRCA = 4'd0; ISRCB = 4'd0;
        ISRCC = 4'd0; ISRCD = 4'd0; ICIN = 1'b0; WEN = 1'b0; WADDR = 4'd0;
        WDATA = '0; WSIZE = 2'd0; RADDR = 4'd0;

        // Reset state
        #12;
        chk("rst_iready", {63'd0, IREADY}, 64'd0);
        chk("rst_act", {63'd0, ACT}, 64'd0);
        chk("rst_flags", {60'd0, FLAGS}, 64'd0);
        chk("rst_busy", {63'd0, BUSY}, 64'd0);
        chk("rst_a", A, 64'd0);
        IVALID = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        tick();

        // Loads r1=5, r2=3 (size 11); WEN holds off issue
        set_op(4'd3, 4'd1, 4'd2);
        WEN = 1'b1; WADDR = 4'd1; WDATA = 64'h5; WSIZE = 2'd3;
        #1 chk("wen_blocks_iready", {63'd0, IREADY}, 64'd0);
        tick();
        WADDR = 4'd2; WDATA = 64'h3;
        tick();
        WEN = 1'b0; RADDR = 4'd1;
        #1 chk("add_iready", {63'd0, IREADY}, 64'd1);
        chk("r1_load", RDATA, 64'h5);
        chk("r1_size", {62'd0, RSIZE}, 64'd3);
        tick();
        chk("add_act", {63'd0, ACT}, 64'd1);
        chk("add_op", {61'd0, OpCODE}, 64'd3);
        chk("add_dsti", {60'd0, DSTi}, 64'd3);
        chk("add_a", A, 64'h5);
        chk("add_b", B, 64'h3);
        chk("add_sa", {62'd0, SA}, 64'd3);
        chk("add_busy", {63'd0, BUSY}, 64'd1);

        // Dependent op r9 = r3 + r1 presented right after the add
        set_op(4'd9, 4'd3, 4'd1);
        RADDR = 4'd3;
        stalls = 0; acc = 1'b0;
        for (int n = 0; n < 8 && !acc; n++) begin
            #1;
            if (IREADY) acc = 1'b1;
            else begin
                stalls++;
                tick();
            end
        end
        chk("dep_accepted", {63'd0, acc}, 64'd1);
        chk("dep_stalls", 64'(stalls), 64'(EXP_STALLS));
        tick();
        IVALID = 1'b0;
        chk("dep_act", {63'd0, ACT}, 64'd1);
        chk("dep_a", A, 64'h8);
        chk("dep_b", B, 64'h5);
        chk("dep_sa", {62'd0, SA}, 64'd3);
        #1 chk("r3_wb", RDATA, 64'h8);
        chk("r3_size", {62'd0, RSIZE}, 64'd3);
        chk("add_flags", {60'd0, FLAGS}, 64'd0);
        drain("dep_drain");
        RADDR = 4'd9;
        #1 chk("r9_wb", RDATA, 64'hD);

        // Three independent ops back to back
        set_op(4'd4, 4'd1, 4'd2);
        #1 chk("tri_rdy0", {63'd0, IREADY}, 64'd1);
        tick();
        chk("tri_act0", {63'd0, ACT}, 64'd1);
        set_op(4'd5, 4'd2, 4'd2);
        #1 chk("tri_rdy1", {63'd0, IREADY}, 64'd1);
        tick();
        chk("tri_act1", {63'd0, ACT}, 64'd1);
        set_op(4'd6, 4'd1, 4'd1);
        #1 chk("tri_rdy2", {63'd0, IREADY}, 64'd1);
        tick();
        chk("tri_act2", {63'd0, ACT}, 64'd1);
        IVALID = 1'b0;
        tick();
        chk("tri_act_off", {63'd0, ACT}, 64'd0);
        RADDR = 4'd4;
        #1 chk("tri_r4", RDATA, 64'h8);
        RADDR = 4'd5;
        #1 chk("tri_r5_pending", RDATA, 64'h0);
        tick();
        #1 chk("tri_r5", RDATA, 64'h6);
        chk("tri_busy_mid", {63'd0, BUSY}, 64'd1);
        RADDR = 4'd6;
        #1 chk("tri_r6_pending", RDATA, 64'h0);
        tick();
        #1 chk("tri_r6", RDATA, 64'hA);
        chk("tri_busy_done", {63'd0, BUSY}, 64'd0);

        // 8-bit signed overflow: 7F + 01
        WEN = 1'b1; WADDR = 4'd7; WDATA = 64'h7F; WSIZE = 2'd0;
        tick();
        WADDR = 4'd8; WDATA = 64'h01;
        tick();
        WEN = 1'b0;
        set_op(4'd10, 4'd7, 4'd8);
        #1 chk("ovf_rdy", {63'd0, IREADY}, 64'd1);
        tick();
        IVALID = 1'b0;
        tick(); tick(); tick();
        RADDR = 4'd10;
        #1 chk("ovf_r10", RDATA, 64'h80);
        chk("ovf_size", {62'd0, RSIZE}, 64'd0);
        chk("ovf_flags", {60'd0, FLAGS}, 64'h5);

        // WEN to an in-flight destination is dropped; WEN elsewhere during
        // the writeback cycle still lands
        set_op(4'd11, 4'd7, 4'd8);
        #1 chk("wbusy_rdy", {63'd0, IREADY}, 64'd1);
        tick();
        set_op(4'd12, 4'd1, 4'd1);
        WEN = 1'b1; WADDR = 4'd11; WDATA = 64'hDEAD; WSIZE = 2'd1;
        #1 chk("wbusy_iready0", {63'd0, IREADY}, 64'd0);
        tick();
        #1 chk("wbusy_iready1", {63'd0, IREADY}, 64'd0);
        tick();
        IVALID = 1'b0; WADDR = 4'd12; WDATA = 64'h55; WSIZE = 2'd1;
        tick();
        WEN = 1'b0; RADDR = 4'd11;
        #1 chk("wbusy_r11", RDATA, 64'h80);
        chk("wbusy_r11_size", {62'd0, RSIZE}, 64'd0);
        chk("wbusy_flags", {60'd0, FLAGS}, 64'h5);
        RADDR = 4'd12;
        #1 chk("wen_r12", RDATA, 64'h55);
        chk("wen_r12_size", {62'd0, RSIZE}, 64'd1);

        // Reset with two ops in flight
        set_op(4'd13, 4'd1, 4'd2);
        tick();
        set_op(4'd14, 4'd1, 4'd1);
        tick();
        IVALID = 1'b0;
        chk("inflight_busy", {63'd0, BUSY}, 64'd1);
        RESET = 1'b0;
        #1 chk("mid_rst_act", {63'd0, ACT}, 64'd0);
        chk("mid_rst_busy", {63'd0, BUSY}, 64'd0);
        chk("mid_rst_iready", {63'd0, IREADY}, 64'd0);
        chk("mid_rst_flags", {60'd0, FLAGS}, 64'd0);
        tick(); tick();
        RESET = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_busy", {63'd0, BUSY}, 64'd0);
        chk("post_rst_act", {63'd0, ACT}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            RADDR = 4'(i);
            #1 chk($sformatf("post_rst_r%0d", i), RDATA, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
